console_writer: RTL and testbench
=================================

Name: console_writer

Overview:
- Sequencer that owns the write side of the text-console video RAM (VRAM; 40x30 character cells, 11-bit address).
- Accepts a character stream over a valid/ready handshake and maintains a cursor. Interprets the control codes CR, LF, BS and FF.
- Performs clear-screen and clear-row fills.
- Writes only in cycles where the display read pipeline does not own VRAM; the display always has priority.

Parameters:
- SCREEN_W, 40, characters per row.
- SCREEN_H, 30, rows per screen.
- AW, 11, VRAM address width.
- DW, 8, VRAM data width.
- BLANK_CHAR, 8'h20, fill code used by clears.

Ports:
- px_clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- char_i  in  8  incoming character code.
- char_valid_i  in  1  char_i valid.
- char_ready_o  out  1  block can accept a character this cycle.
- disp_active_i  in  1  display owns VRAM this cycle; no write may issue.
- we_vram  out  1  VRAM write strobe.
- addr_w  out  AW  VRAM write address.
- data_w  out  DW  VRAM write data.
- cursor_x  out  6  cursor column, 0..SCREEN_W-1.
- cursor_y  out  5  cursor row, 0..SCREEN_H-1.
- busy  out  1  FSM not in IDLE.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values:
  - State is CLEAR with fill counter 0.
  - cursor_x=0, cursor_y=0.
  - char_ready_o=0, busy=1.
  - addr_w=0, data_w=BLANK_CHAR.
  - we_vram=0 during the reset cycle.
- we_vram = (state is CLEAR, CLRROW or WRITE) AND NOT disp_active_i. It is combinational from the registered state, so it is never asserted while disp_active_i=1.
- addr_w and data_w are registered and stay stable while a write is pending.
- FSM states:
  - CLEAR: addr_w = fill counter, data_w = BLANK_CHAR. On each granted cycle (we_vram=1) the counter increments. After the grant at address SCREEN_W*SCREEN_H-1 (1199), go to IDLE with the cursor at (0,0).
  - IDLE: char_ready_o=1; this is the only state where it is high. A handshake occurs when char_valid_i & char_ready_o; decode char_i in that cycle.
    - 0x20..0x7E: go to WRITE with addr_w = cursor_y*SCREEN_W + cursor_x (11-bit, no overflow) and data_w = char_i.
    - 0x0D (CR): cursor_x=0, stay IDLE.
    - 0x0A (LF): cursor_x=0, then apply the newline rule.
    - 0x08 (BS): if cursor_x>0, decrement it; no write. At cursor_x=0, no change.
    - 0x0C (FF): cursor to (0,0), go to CLEAR with counter 0.
    - Any other code: consumed and ignored.
  - WRITE: hold until the first granted cycle, then advance the cursor.
    - If cursor_x < SCREEN_W-1: cursor_x+1, go to IDLE.
    - Else: cursor_x=0 and apply the newline rule.
  - Newline rule: cursor_y+1, wrapping from SCREEN_H-1 to 0. Then go to CLRROW with addr_w = new_row*SCREEN_W, counting SCREEN_W cells. If ROW_CLEAR_EN is undefined, go to IDLE instead.
  - CLRROW: write BLANK_CHAR on each granted cycle. Go to IDLE after the grant at row_base+SCREEN_W-1.
- Latency: a printable character accepted at cycle N with disp_active_i low produces we_vram at N+1. The next char_ready_o is at N+2.
- Reset mid-fill or mid-write aborts the operation and restarts CLEAR from 0.
- char_valid_i is ignored in every state except IDLE.

Optional Feature:
- Macro ROW_CLEAR_EN.
- Defined: each newline blanks the row the cursor enters (CLRROW state exists).
- Undefined: the CLRROW state is not generated. A newline returns directly to IDLE and the old row contents remain.

Decomposition:
- Package console_pkg holds:
  - the FSM state enum (CLEAR, IDLE, WRITE, CLRROW);
  - control-code constants CC_CR, CC_LF, CC_BS, CC_FF;
  - SCREEN_W/SCREEN_H defaults;
  - the printable-range limits.
- Sub-module console_cursor holds cursor_x/cursor_y registers, advance/newline/CR/BS/home commands, and wrap logic. It produces the linear cell address cursor_y*SCREEN_W+cursor_x and the row base.

Test Plan:
- Reset, disp_active_i=0 -> 1200 consecutive we_vram pulses at addr 0..1199 with data 0x20, then char_ready_o=1 and cursor (0,0).
- Send 'A' (0x41) at cursor (0,0) while disp_active_i=1 for 5 cycles -> no we_vram during those cycles. One write to addr 0 with data 0x41 on the first low cycle, then cursor (1,0).
- Cursor (39,2), send 0x42 -> write at addr 119. Cursor becomes (0,3), followed by 40 writes of 0x20 at addr 120..159 (ROW_CLEAR_EN defined) or none (undefined).
- Cursor (5,29), send LF -> cursor (0,0) and row 0 cleared (addr 0..39). Then BS at x=0 -> no change and no write.
- Send FF mid-screen -> full 1200-cell clear and cursor (0,0). Assert reset at fill count 600 -> fill restarts at addr 0.
- Send 0x07 and 0x7F -> consumed with char_ready_o handshake, no write, cursor unchanged.

Source files
------------

// File: rtl/console_pkg.sv
// Shared types and constants for the text-console writer.
package console_pkg;

    localparam int SCREEN_W_DEF = 40;
    localparam int SCREEN_H_DEF = 30;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WRITE,
        ST_CLRROW
    } state_e;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_ADV,
        CUR_NL,
        CUR_CR,
        CUR_BS,
        CUR_HOME
    } cur_cmd_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_LO) && (c <= PRINT_HI);
    endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor position registers with advance/newline/CR/BS/home commands and row wrap.
// The next-row base output exists only when ROW_CLEAR_EN is defined.
module console_cursor
    import console_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int AW       = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  cur_cmd_e      cmd_i,
`ifdef ROW_CLEAR_EN
    output logic [AW-1:0] nl_base_o,
`endif
    output logic [5:0]    x_o,
    output logic [4:0]    y_o,
    output logic [AW-1:0] cell_addr_o
);

    logic [5:0] x_q, x_d;
    logic [4:0] y_q, y_d;
    logic [4:0] y_nl;

    assign y_nl = (y_q == 5'(SCREEN_H - 1)) ? 5'd0 : y_q + 5'd1;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        case (cmd_i)
            CUR_ADV: begin
                if (x_q == 6'(SCREEN_W - 1)) begin
                    x_d = 6'd0;
                    y_d = y_nl;
                end else begin
                    x_d = x_q + 6'd1;
                end
            end
            CUR_NL: begin
                x_d = 6'd0;
                y_d = y_nl;
            end
            CUR_CR:   x_d = 6'd0;
            CUR_BS:   if (x_q != 6'd0) x_d = x_q - 6'd1;
            CUR_HOME: begin
                x_d = 6'd0;
                y_d = 5'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q <= 6'd0;
            y_q <= 5'd0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o         = x_q;
    assign y_o         = y_q;
    assign cell_addr_o = AW'(y_q) * AW'(SCREEN_W) + AW'(x_q);
`ifdef ROW_CLEAR_EN
    assign nl_base_o   = AW'(y_nl) * AW'(SCREEN_W);
`endif

endmodule

// File: rtl/console_writer.sv
// VRAM write-side sequencer for the 40x30 text console; display reads always win.
// Define ROW_CLEAR_EN to blank each row the cursor enters on a newline.
//
// state  | meaning
// CLEAR  | fill whole screen with BLANK_CHAR, one cell per granted cycle
// IDLE   | accept and decode one character
// WRITE  | one printable character pending until granted
// CLRROW | fill the freshly entered row with BLANK_CHAR (ROW_CLEAR_EN only)
module console_writer
    import console_pkg::*;
#(
    parameter int              SCREEN_W   = SCREEN_W_DEF,
    parameter int              SCREEN_H   = SCREEN_H_DEF,
    parameter int              AW         = 11,
    parameter int              DW         = 8,
    parameter logic [DW-1:0]   BLANK_CHAR = 8'h20
) (
    input  logic          px_clk,
    input  logic          reset,
    input  logic [7:0]    char_i,
    input  logic          char_valid_i,
    output logic          char_ready_o,
    input  logic          disp_active_i,
    output logic          we_vram,
    output logic [AW-1:0] addr_w,
    output logic [DW-1:0] data_w,
    output logic [5:0]    cursor_x,
    output logic [4:0]    cursor_y,
    output logic          busy
);

    localparam logic [AW-1:0] CELLS_LAST = AW'(SCREEN_W * SCREEN_H - 1);
`ifdef ROW_CLEAR_EN
    localparam logic [AW-1:0] ROW_LAST   = AW'(SCREEN_W - 1);
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] cnt_q, cnt_d;   // cells remaining after the current one
    cur_cmd_e      cmd;
    logic          grant;
    logic [AW-1:0] cell_addr;
`ifdef ROW_CLEAR_EN
    logic [AW-1:0] nl_base;
`endif

    console_cursor #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .AW       (AW)
    ) u_cursor (
        .clk_i       (px_clk),
        .rst_i       (reset),
        .cmd_i       (cmd),
`ifdef ROW_CLEAR_EN
        .nl_base_o   (nl_base),
`endif
        .x_o         (cursor_x),
        .y_o         (cursor_y),
        .cell_addr_o (cell_addr)
    );

    // Reset gates the strobe so nothing is written during the reset cycle itself.
    assign grant        = (state_q != ST_IDLE) && !disp_active_i && !reset;
    assign we_vram      = grant;
    assign char_ready_o = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign addr_w       = addr_q;
    assign data_w       = data_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        cmd     = CUR_NONE;
        case (state_q)
            ST_CLEAR: begin
                if (grant) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        cmd     = CUR_HOME;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        cnt_d  = cnt_q - 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (char_valid_i) begin
                    if (is_printable(char_i)) begin
                        state_d = ST_WRITE;
                        addr_d  = cell_addr;
                        data_d  = DW'(char_i);
                    end else begin
                        case (char_i)
                            CC_CR: cmd = CUR_CR;
                            CC_LF: begin
                                cmd = CUR_NL;
`ifdef ROW_CLEAR_EN
                                state_d = ST_CLRROW;
                                addr_d  = nl_base;
                                cnt_d   = ROW_LAST;
                                data_d  = BLANK_CHAR;
`endif
                            end
                            CC_BS: cmd = CUR_BS;
                            CC_FF: begin
                                cmd     = CUR_HOME;
                                state_d = ST_CLEAR;
                                addr_d  = '0;
                                cnt_d   = CELLS_LAST;
                                data_d  = BLANK_CHAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_WRITE: begin
                if (grant) begin
                    if (cursor_x < 6'(SCREEN_W - 1)) begin
                        cmd     = CUR_ADV;
                        state_d = ST_IDLE;
                    end else begin
                        cmd     = CUR_NL;
`ifdef ROW_CLEAR_EN
                        state_d = ST_CLRROW;
                        addr_d  = nl_base;
                        cnt_d   = ROW_LAST;
                        data_d  = BLANK_CHAR;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef ROW_CLEAR_EN
            ST_CLRROW: begin
                if (grant) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        cnt_d  = cnt_q - 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            addr_q  <= '0;
            data_q  <= BLANK_CHAR;
            cnt_q   <= CELLS_LAST;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_console_writer.sv
// Directed self-checking bench for console_writer; expectations follow ROW_CLEAR_EN.
module tb_console_writer;

    logic        px_clk = 1'b0;
    logic        reset;
    logic [7:0]  char_i;
    logic        char_valid_i;
    logic        char_ready_o;
    logic        disp_active_i;
    logic        we_vram;
    logic [10:0] addr_w;
    logic [7:0]  data_w;
    logic [5:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    int checks = 0;
    int errors = 0;

    console_writer dut (
        .px_clk        (px_clk),
        .reset         (reset),
        .char_i        (char_i),
        .char_valid_i  (char_valid_i),
        .char_ready_o  (char_ready_o),
        .disp_active_i (disp_active_i),
        .we_vram       (we_vram),
        .addr_w        (addr_w),
        .data_w        (data_w),
        .cursor_x      (cursor_x),
        .cursor_y      (cursor_y),
        .busy          (busy)
    );

    always #5 px_clk = ~px_clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask

    // Entered and left just after a rising edge; returns one cycle after the handshake edge.
    task automatic send_char(input logic [7:0] c);
        int n = 0;
        char_i       = c;
        char_valid_i = 1'b1;
        @(negedge px_clk);
        while (char_ready_o !== 1'b1 && n < 3000) begin
            @(negedge px_clk);
            n++;
        end
        checks++;
        if (char_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL send_char_timeout char=%h ready=%b required 1", c, char_ready_o);
        end
        tick();
        char_valid_i = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge px_clk);
        while (char_ready_o !== 1'b1 && n < 3000) begin
            @(negedge px_clk);
            n++;
        end
        checks++;
        if (char_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready_timeout ready=%b required 1", char_ready_o);
        end
        tick();
    endtask

    task automatic put(input logic [7:0] c);
        send_char(c);
        wait_ready();
    endtask

    task automatic test_reset();
        int bad = 0;
        reset = 1'b1; char_valid_i = 1'b0; disp_active_i = 1'b0; char_i = 8'h00;
        repeat (3) tick();
        @(negedge px_clk);
        checks++; if (we_vram !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", we_vram); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
        checks++; if (char_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", char_ready_o); end
        checks++; if (addr_w !== 11'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", addr_w); end
        checks++; if (data_w !== 8'h20) begin errors++; $display("FAIL rst_data got %h want 20", data_w); end
        checks++; if (cursor_x !== 6'd0 || cursor_y !== 5'd0) begin errors++; $display("FAIL rst_cursor got (%0d,%0d) want (0,0)", cursor_x, cursor_y); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge px_clk);
            if (we_vram !== 1'b1 || addr_w !== 11'(i) || data_w !== 8'h20) begin
                if (bad == 0) $display("cell %0d: we=%b addr=%0d data=%h", i, we_vram, addr_w, data_w);
                bad++;
            end
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_clear_fill bad_cells got %0d want 0", bad); end
        @(negedge px_clk);
        checks++; if (char_ready_o !== 1'b1 || busy !== 1'b0 || we_vram !== 1'b0) begin errors++; $display("FAIL rst_idle ready=%b busy=%b we=%b want 1 0 0", char_ready_o, busy, we_vram); end
        checks++; if (cursor_x !== 6'd0 || cursor_y !== 5'd0) begin errors++; $display("FAIL rst_idle_cursor got (%0d,%0d) want (0,0)", cursor_x, cursor_y); end
        tick();
    endtask

    task automatic test_disp_priority();
        int bad = 0;
        disp_active_i = 1'b1;
        send_char(8'h41);
        for (int k = 0; k < 5; k++) begin
            @(negedge px_clk);
            if (we_vram !== 1'b0 || char_ready_o !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL disp_stall bad_cycles got %0d want 0", bad); end
        checks++; if (addr_w !== 11'd0 || data_w !== 8'h41) begin errors++; $display("FAIL disp_hold addr=%0d data=%h want 0 41", addr_w, data_w); end
        disp_active_i = 1'b0;
        @(negedge px_clk);
        checks++; if (we_vram !== 1'b1 || addr_w !== 11'd0 || data_w !== 8'h41) begin errors++; $display("FAIL disp_release we=%b addr=%0d data=%h want 1 0 41", we_vram, addr_w, data_w); end
        tick();
        @(negedge px_clk);
        checks++; if (cursor_x !== 6'd1 || cursor_y !== 5'd0 || char_ready_o !== 1'b1) begin errors++; $display("FAIL disp_after cursor=(%0d,%0d) ready=%b want (1,0) 1", cursor_x, cursor_y, char_ready_o); end
        tick();
    endtask

    task automatic test_row_wrap();
        int bad = 0;
        put(8'h0A);
        put(8'h0A);
        for (int i = 0; i < 39; i++) put(8'h41);
        @(negedge px_clk);
        checks++; if (cursor_x !== 6'd39 || cursor_y !== 5'd2) begin errors++; $display("FAIL wrap_pos got (%0d,%0d) want (39,2)", cursor_x, cursor_y); end
        tick();
        send_char(8'h42);
        @(negedge px_clk);
        checks++; if (we_vram !== 1'b1 || addr_w !== 11'd119 || data_w !== 8'h42) begin errors++; $display("FAIL wrap_write we=%b addr=%0d data=%h want 1 119 42", we_vram, addr_w, data_w); end
        tick();
`ifdef ROW_CLEAR_EN
        for (int i = 0; i < 40; i++) begin
            @(negedge px_clk);
            if (we_vram !== 1'b1 || addr_w !== 11'(120 + i) || data_w !== 8'h20 ||
                cursor_x !== 6'd0 || cursor_y !== 5'd3) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_rowclear bad_cells got %0d want 0", bad); end
`endif
        @(negedge px_clk);
        checks++; if (char_ready_o !== 1'b1 || we_vram !== 1'b0 || cursor_x !== 6'd0 || cursor_y !== 5'd3) begin
            errors++; $display("FAIL wrap_end ready=%b we=%b cursor=(%0d,%0d) want 1 0 (0,3)", char_ready_o, we_vram, cursor_x, cursor_y);
        end
        tick();
    endtask

    task automatic test_lf_wrap_bs_cr();
        int bad = 0;
        repeat (26) put(8'h0A);
        @(negedge px_clk);
        checks++; if (cursor_x !== 6'd0 || cursor_y !== 5'd29) begin errors++; $display("FAIL lf_last_row got (%0d,%0d) want (0,29)", cursor_x, cursor_y); end
        tick();
        repeat (5) put(8'h43);
        send_char(8'h0A);
`ifdef ROW_CLEAR_EN
        for (int i = 0; i < 40; i++) begin
            @(negedge px_clk);
            if (we_vram !== 1'b1 || addr_w !== 11'(i) || data_w !== 8'h20 ||
                cursor_x !== 6'd0 || cursor_y !== 5'd0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL lf_row0_clear bad_cells got %0d want 0", bad); end
`endif
        @(negedge px_clk);
        checks++; if (cursor_x !== 6'd0 || cursor_y !== 5'd0 || char_ready_o !== 1'b1 || we_vram !== 1'b0) begin
            errors++; $display("FAIL lf_wrap cursor=(%0d,%0d) ready=%b we=%b want (0,0) 1 0", cursor_x, cursor_y, char_ready_o, we_vram);
        end
        tick();
        send_char(8'h08);
        @(negedge px_clk);
        checks++; if (cursor_x !== 6'd0 || cursor_y !== 5'd0 || we_vram !== 1'b0 || char_ready_o !== 1'b1) begin
            errors++; $display("FAIL bs_at_zero cursor=(%0d,%0d) we=%b ready=%b want (0,0) 0 1", cursor_x, cursor_y, we_vram, char_ready_o);
        end
        tick();
        put(8'h43);
        send_char(8'h08);
        @(negedge px_clk);
        checks++; if (cursor_x !== 6'd0 || we_vram !== 1'b0) begin errors++; $display("FAIL bs_dec x=%0d we=%b want 0 0", cursor_x, we_vram); end
        tick();
        repeat (3) put(8'h43);
        send_char(8'h0D);
        @(negedge px_clk);
        checks++; if (cursor_x !== 6'd0 || cursor_y !== 5'd0 || we_vram !== 1'b0) begin errors++; $display("FAIL cr cursor=(%0d,%0d) we=%b want (0,0) 0", cursor_x, cursor_y, we_vram); end
        tick();
        put(8'h0A);
        put(8'h44);
    endtask

    task automatic test_ff_and_reset();
        int bad = 0;
        int exp_a = 0;
        int cyc = 0;
        logic exp_we;
        send_char(8'h0C);
        while (exp_a < 1200 && cyc < 1400) begin
            disp_active_i = (cyc >= 300 && cyc < 303);
            exp_we = !disp_active_i;
            @(negedge px_clk);
            if (we_vram !== exp_we || addr_w !== 11'(exp_a) || data_w !== 8'h20 || busy !== 1'b1 ||
                (cyc == 0 && (cursor_x !== 6'd0 || cursor_y !== 5'd0))) bad++;
            if (exp_we) exp_a++;
            cyc++;
            tick();
        end
        disp_active_i = 1'b0;
        checks++; if (bad != 0 || cyc != 1203) begin errors++; $display("FAIL ff_clear bad_cells=%0d cycles=%0d want 0 1203", bad, cyc); end
        @(negedge px_clk);
        checks++; if (char_ready_o !== 1'b1 || cursor_x !== 6'd0 || cursor_y !== 5'd0) begin errors++; $display("FAIL ff_done ready=%b cursor=(%0d,%0d) want 1 (0,0)", char_ready_o, cursor_x, cursor_y); end
        tick();

        bad = 0;
        send_char(8'h0C);
        for (int i = 0; i < 600; i++) begin
            @(negedge px_clk);
            if (we_vram !== 1'b1 || addr_w !== 11'(i)) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ff_partial bad_cells got %0d want 0", bad); end
        reset = 1'b1;
        @(negedge px_clk);
        checks++; if (we_vram !== 1'b0 || addr_w !== 11'd600) begin errors++; $display("FAIL midfill_reset we=%b addr=%0d want 0 600", we_vram, addr_w); end
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge px_clk);
            if (we_vram !== 1'b1 || addr_w !== 11'(i) || data_w !== 8'h20) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL refill bad_cells got %0d want 0", bad); end
        @(negedge px_clk);
        checks++; if (char_ready_o !== 1'b1 || cursor_x !== 6'd0 || cursor_y !== 5'd0) begin errors++; $display("FAIL refill_done ready=%b cursor=(%0d,%0d) want 1 (0,0)", char_ready_o, cursor_x, cursor_y); end
        tick();
    endtask

    task automatic test_ignored_and_back_to_back();
        put(8'h5A);
        send_char(8'h07);
        @(negedge px_clk);
        checks++; if (we_vram !== 1'b0 || char_ready_o !== 1'b1 || busy !== 1'b0 || cursor_x !== 6'd1 || cursor_y !== 5'd0) begin
            errors++; $display("FAIL ignore_07 we=%b ready=%b busy=%b cursor=(%0d,%0d) want 0 1 0 (1,0)", we_vram, char_ready_o, busy, cursor_x, cursor_y);
        end
        tick();
        send_char(8'h7F);
        @(negedge px_clk);
        checks++; if (we_vram !== 1'b0 || char_ready_o !== 1'b1 || cursor_x !== 6'd1 || cursor_y !== 5'd0) begin
            errors++; $display("FAIL ignore_7f we=%b ready=%b cursor=(%0d,%0d) want 0 1 (1,0)", we_vram, char_ready_o, cursor_x, cursor_y);
        end
        tick();
        send_char(8'h45);
        @(negedge px_clk);
        checks++; if (we_vram !== 1'b1 || addr_w !== 11'd1 || data_w !== 8'h45 || char_ready_o !== 1'b0) begin
            errors++; $display("FAIL latency_n1 we=%b addr=%0d data=%h ready=%b want 1 1 45 0", we_vram, addr_w, data_w, char_ready_o);
        end
        tick();
        @(negedge px_clk);
        checks++; if (char_ready_o !== 1'b1 || cursor_x !== 6'd2) begin errors++; $display("FAIL latency_n2 ready=%b x=%0d want 1 2", char_ready_o, cursor_x); end
        tick();
    endtask

    initial begin
        test_reset();
        test_disp_priority();
        test_row_wrap();
        test_lf_wrap_bs_cr();
        test_ff_and_reset();
        test_ignored_and_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
